counter_mod_updown: RTL and testbench

Parametrised up/down counter with programmable modulo, wrap or saturate mode, synchronous load, enable, and a clock-enable prescaler. It is the general-purpose counter for timers, display multiplexing and event counting, replacing fixed free-running power-of-two counters. It flags boundary crossings with a single-cycle terminal-count pulse.

---
 rtl/counter_mod_updown_pkg.sv | 22 ++
 rtl/counter_mod_updown_if.sv | 24 ++
 rtl/counter_mod_updown_tick_prescaler.sv | 34 +++
 rtl/counter_mod_updown.sv | 98 +++++++++
 tb/tb_counter_mod_updown.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/counter_mod_updown_pkg.sv
// Purpose: shared types and helpers for the modulo up/down counter.
//   cnt_dir_e  : step direction (DIR_DOWN / DIR_UP)
//   cnt_mode_e : bound behaviour (MODE_WRAP / MODE_SAT)
//   psc_width  : register width needed for a prescaler counting 0..prescale-1
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  // At least one bit, even when the prescaler is a pass-through.
  function automatic int unsigned psc_width(input int unsigned prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/counter_mod_updown_if.sv
// Purpose: control/status bundle of counter_mod_updown.
//   master : drives en, dir, sat, load, load_val; observes count, tc
//   slave  : the counter itself
interface counter_mod_updown_if #(
  parameter int unsigned N = 8
);
  logic         en;
  logic         dir;
  logic         sat;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] count;
  logic         tc;

  modport master (
    output en, dir, sat, load, load_val,
    input  count, tc
  );

  modport slave (
    input  en, dir, sat, load, load_val,
    output count, tc
  );
endinterface

// File: rtl/counter_mod_updown_tick_prescaler.sv
// Purpose: clock-enable prescaler; one tick every PRESCALE enabled cycles.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous restart of the prescale count (driven by load)
//   en         : advance enable
//   tick       : combinational, en && psc == PRESCALE-1
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned   PW       = psc_width(PRESCALE);
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc;

  // Prescale counter; clr discards any partial count.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      psc <= '0;
    end else if (en) begin
      psc <= (psc == PSC_LAST) ? '0 : psc + PW'(1);
    end
  end

  assign tick = en && (psc == PSC_LAST);

endmodule

// File: rtl/counter_mod_updown.sv
// Purpose: up/down counter with programmable modulo, wrap/saturate mode,
//          synchronous load, enable and clock-enable prescaler.
//   clk, reset : clock, synchronous active-high reset
//   bus.en     : count enable (gates prescaler and stepping)
//   bus.dir    : 1 = up, 0 = down
//   bus.sat    : 1 = saturate, 0 = wrap
//   bus.load   : load min(load_val, MOD-1); restarts the prescaler
//   bus.count  : registered count, always in 0..MOD-1
//   bus.tc     : registered one-cycle pulse on wrap or blocked step
module counter_mod_updown
  import counter_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned MOD      = 256,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_mod_updown_if.slave  bus
);

  // One extra bit so MOD = 2^N compares against MOD-1 without aliasing.
  localparam int unsigned  W   = N + 1;
  localparam logic [W-1:0] MAX = W'(MOD - 1);

  if (N < 1 || N > 31) begin : g_bad_n
    $error("counter_mod_updown: N must be in 1..31");
  end
  if (MOD < 2 || 64'(MOD) > (64'(1) << N)) begin : g_bad_mod
    $error("counter_mod_updown: MOD must be in 2..2^N");
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_psc
    $error("counter_mod_updown: PRESCALE must be in 1..65536");
  end

  logic         step;
  logic [N-1:0] count_q;
  logic         tc_q;
  logic [N-1:0] next_count;
  logic         next_tc;
  logic         at_bound;
  logic [W-1:0] cnt_ext;
  logic [W-1:0] ld_ext;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_tick_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.load),
    .en    (bus.en),
    .tick  (step)
  );

  // Next count and terminal-count; load beats step, tc only on step edges.
  always_comb begin
    cnt_ext    = {1'b0, count_q};
    ld_ext     = {1'b0, bus.load_val};
    next_count = count_q;
    next_tc    = 1'b0;
    at_bound   = 1'b0;
    if (bus.load) begin
      next_count = (ld_ext > MAX) ? N'(MAX) : bus.load_val;
    end else if (step) begin
      if (cnt_dir_e'(bus.dir) == DIR_UP) begin
        at_bound = (cnt_ext == MAX);
        if (!at_bound) begin
          next_count = N'(cnt_ext + W'(1));
        end else if (cnt_mode_e'(bus.sat) == MODE_WRAP) begin
          next_count = '0;
        end
      end else begin
        at_bound = (cnt_ext == '0);
        if (!at_bound) begin
          next_count = N'(cnt_ext - W'(1));
        end else if (cnt_mode_e'(bus.sat) == MODE_WRAP) begin
          next_count = N'(MAX);
        end
      end
      next_tc = at_bound;
    end
  end

  // Count and tc registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= next_count;
      tc_q    <= next_tc;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Purpose: self-checking bench for counter_mod_updown. Three instances:
//   dut_a N=4 MOD=10 PRESCALE=1, dut_b N=8 MOD=256 PRESCALE=3,
//   dut_c N=4 MOD=16 PRESCALE=1. Directed scenarios plus random traffic
//   compared against an arithmetic reference model.
module tb_counter_mod_updown;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  counter_mod_updown_if #(.N(4)) ifa ();
  counter_mod_updown_if #(.N(8)) ifb ();
  counter_mod_updown_if #(.N(4)) ifc ();

  counter_mod_updown #(.N(4), .MOD(10), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  counter_mod_updown #(.N(8), .MOD(256), .PRESCALE(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));
  counter_mod_updown #(.N(4), .MOD(16), .PRESCALE(1)) dut_c (
    .clk(clk), .reset(reset), .bus(ifc));

  // Reference model state per instance.
  int a_cnt = 0, a_psc = 0, b_cnt = 0, b_psc = 0, c_cnt = 0, c_psc = 0;
  bit a_tc = 0, b_tc = 0, c_tc = 0;

  // One clock edge of the specified behaviour, in plain integer arithmetic.
  task automatic model_next(input int mod, input int prescale, input bit rst,
                            input bit ld, input bit e, input bit d, input bit s,
                            input int lv, inout int cnt, inout int psc,
                            inout bit tc);
    int target;
    if (rst) begin
      cnt = 0; psc = 0; tc = 0;
    end else if (ld) begin
      cnt = (lv < mod) ? lv : mod - 1; psc = 0; tc = 0;
    end else if (e && psc == prescale - 1) begin
      psc    = 0;
      target = cnt + (d ? 1 : -1);
      if (target >= 0 && target < mod) begin
        cnt = target; tc = 0;
      end else begin
        tc = 1;
        if (!s) cnt = (target + mod) % mod;
      end
    end else begin
      if (e) psc = psc + 1;
      tc = 0;
    end
  endtask

  // Advance models with the inputs presented this cycle, then clock.
  task automatic tick();
    model_next(10, 1, reset, ifa.load, ifa.en, ifa.dir, ifa.sat,
               int'(ifa.load_val), a_cnt, a_psc, a_tc);
    model_next(256, 3, reset, ifb.load, ifb.en, ifb.dir, ifb.sat,
               int'(ifb.load_val), b_cnt, b_psc, b_tc);
    model_next(16, 1, reset, ifc.load, ifc.en, ifc.dir, ifc.sat,
               int'(ifc.load_val), c_cnt, c_psc, c_tc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.en = 0; ifa.dir = 0; ifa.sat = 0; ifa.load = 0; ifa.load_val = '0;
    ifb.en = 0; ifb.dir = 0; ifb.sat = 0; ifb.load = 0; ifb.load_val = '0;
    ifc.en = 0; ifc.dir = 0; ifc.sat = 0; ifc.load = 0; ifc.load_val = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    ifa.en = 1; ifb.en = 1; ifc.en = 1;
    ifa.load = 1; ifa.load_val = 4'd5;
    tick();
    n_cmp++; if (ifa.count !== 4'd0) begin n_fail++; $display("FAIL reset_a_count: got %0d want 0", ifa.count); end
    n_cmp++; if (ifa.tc !== 1'b0) begin n_fail++; $display("FAIL reset_a_tc: got %0b want 0", ifa.tc); end
    n_cmp++; if (ifb.count !== 8'd0) begin n_fail++; $display("FAIL reset_b_count: got %0d want 0", ifb.count); end
    n_cmp++; if (ifb.tc !== 1'b0) begin n_fail++; $display("FAIL reset_b_tc: got %0b want 0", ifb.tc); end
    n_cmp++; if (ifc.count !== 4'd0) begin n_fail++; $display("FAIL reset_c_count: got %0d want 0", ifc.count); end
    n_cmp++; if (ifc.tc !== 1'b0) begin n_fail++; $display("FAIL reset_c_tc: got %0b want 0", ifc.tc); end
    reset = 0;
    idle();
  endtask

  task automatic test_wrap_up();
    int e;
    idle();
    reset = 1; tick(); reset = 0;
    ifa.en = 1; ifa.dir = 1; ifa.sat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      e = i % 10;
      n_cmp++; if (ifa.count !== 4'(e)) begin n_fail++; $display("FAIL wrap_up_count[%0d]: got %0d want %0d", i, ifa.count, e); end
      n_cmp++; if (ifa.tc !== (e == 0)) begin n_fail++; $display("FAIL wrap_up_tc[%0d]: got %0b want %0b", i, ifa.tc, e == 0); end
    end
    idle();
  endtask

  task automatic test_wrap_down_load();
    int seq [5];
    seq = '{2, 1, 0, 9, 8};
    idle();
    ifa.load = 1; ifa.load_val = 4'd3; tick();
    n_cmp++; if (ifa.count !== 4'd3) begin n_fail++; $display("FAIL wrap_down_load: got %0d want 3", ifa.count); end
    ifa.load = 0; ifa.dir = 0; ifa.en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (ifa.count !== 4'(seq[i])) begin n_fail++; $display("FAIL wrap_down_count[%0d]: got %0d want %0d", i, ifa.count, seq[i]); end
      n_cmp++; if (ifa.tc !== (i == 3)) begin n_fail++; $display("FAIL wrap_down_tc[%0d]: got %0b want %0b", i, ifa.tc, i == 3); end
    end
    idle();
  endtask

  task automatic test_saturate();
    idle();
    ifa.load = 1; ifa.load_val = 4'd8; tick();
    ifa.load = 0; ifa.dir = 1; ifa.sat = 1; ifa.en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (ifa.count !== 4'd9) begin n_fail++; $display("FAIL sat_count[%0d]: got %0d want 9", i, ifa.count); end
      n_cmp++; if (ifa.tc !== (i >= 1)) begin n_fail++; $display("FAIL sat_tc[%0d]: got %0b want %0b", i, ifa.tc, i >= 1); end
    end
    // Saturate at zero going down.
    ifa.load = 1; ifa.load_val = 4'd0; ifa.en = 0; tick();
    ifa.load = 0; ifa.dir = 0; ifa.en = 1; tick();
    n_cmp++; if (ifa.count !== 4'd0 || ifa.tc !== 1'b1) begin n_fail++; $display("FAIL sat_low: got count %0d tc %0b want 0/1", ifa.count, ifa.tc); end
    idle();
  endtask

  task automatic test_prescaler();
    int k;
    idle();
    reset = 1; tick(); reset = 0;
    ifb.dir = 1; ifb.sat = 0;
    k = 0;
    for (int c = 0; c < 11; c++) begin
      ifb.en = !(c == 4 || c == 5);
      tick();
      if (c != 4 && c != 5) k++;
      n_cmp++; if (ifb.count !== 8'(k / 3)) begin n_fail++; $display("FAIL psc_count[%0d]: got %0d want %0d", c, ifb.count, k / 3); end
      n_cmp++; if (ifb.tc !== 1'b0) begin n_fail++; $display("FAIL psc_tc[%0d]: got %0b want 0", c, ifb.tc); end
    end
    // Load mid-prescale restarts: next step lands on the 3rd enabled edge.
    ifb.en = 1; tick();
    ifb.load = 1; ifb.load_val = 8'd50; tick();
    ifb.load = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_cmp++; if (ifb.count !== 8'(c == 3 ? 51 : 50)) begin n_fail++; $display("FAIL psc_load[%0d]: got %0d want %0d", c, ifb.count, c == 3 ? 51 : 50); end
    end
    idle();
  endtask

  task automatic test_load_clamp();
    idle();
    ifa.load = 1; ifa.load_val = 4'd15; tick();
    n_cmp++; if (ifa.count !== 4'd9) begin n_fail++; $display("FAIL clamp: got %0d want 9", ifa.count); end
    ifa.load_val = 4'd4; ifa.en = 1; ifa.dir = 1; ifa.sat = 0; tick();
    n_cmp++; if (ifa.count !== 4'd4) begin n_fail++; $display("FAIL load_prio_count: got %0d want 4", ifa.count); end
    n_cmp++; if (ifa.tc !== 1'b0) begin n_fail++; $display("FAIL load_prio_tc: got %0b want 0", ifa.tc); end
    reset = 1; ifa.load_val = 4'd7; tick();
    n_cmp++; if (ifa.count !== 4'd0) begin n_fail++; $display("FAIL reset_prio: got %0d want 0", ifa.count); end
    reset = 0;
    idle();
  endtask

  task automatic test_full_width();
    int e;
    idle();
    ifc.load = 1; ifc.load_val = 4'd6; tick();
    ifc.load = 0; ifc.en = 1; ifc.dir = 1; ifc.sat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      e = (6 + i) % 16;
      n_cmp++; if (ifc.count !== 4'(e)) begin n_fail++; $display("FAIL full_count[%0d]: got %0d want %0d", i, ifc.count, e); end
      n_cmp++; if (ifc.tc !== (e == 0)) begin n_fail++; $display("FAIL full_tc[%0d]: got %0b want %0b", i, ifc.tc, e == 0); end
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      ifa.load     = ($urandom_range(0, 15) == 0); ifa.load_val = 4'($urandom);
      ifa.en       = ($urandom_range(0, 3) != 0);  ifa.dir = 1'($urandom); ifa.sat = 1'($urandom);
      ifb.load     = ($urandom_range(0, 31) == 0); ifb.load_val = 8'($urandom);
      ifb.en       = ($urandom_range(0, 3) != 0);  ifb.dir = 1'($urandom); ifb.sat = 1'($urandom);
      ifc.load     = ($urandom_range(0, 15) == 0); ifc.load_val = 4'($urandom);
      ifc.en       = ($urandom_range(0, 3) != 0);  ifc.dir = 1'($urandom); ifc.sat = 1'($urandom);
      tick();
      n_cmp++; if (ifa.count !== 4'(a_cnt) || ifa.tc !== a_tc) begin n_fail++; $display("FAIL rand_a[%0d]: got %0d/%0b want %0d/%0b", i, ifa.count, ifa.tc, a_cnt, a_tc); end
      n_cmp++; if (ifb.count !== 8'(b_cnt) || ifb.tc !== b_tc) begin n_fail++; $display("FAIL rand_b[%0d]: got %0d/%0b want %0d/%0b", i, ifb.count, ifb.tc, b_cnt, b_tc); end
      n_cmp++; if (ifc.count !== 4'(c_cnt) || ifc.tc !== c_tc) begin n_fail++; $display("FAIL rand_c[%0d]: got %0d/%0b want %0d/%0b", i, ifc.count, ifc.tc, c_cnt, c_tc); end
    end
    reset = 0;
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    tick();
    tick();
    test_reset();
    test_wrap_up();
    test_wrap_down_load();
    test_saturate();
    test_prescaler();
    test_load_clamp();
    test_full_width();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
